gl_rasterizer_stream: RTL and testbench

GL_RASTERIZER_STREAM -- requirements
Module: gl_rasterizer_stream

---
 rtl/gl_rasterizer_stream.sv | 246 ++++++++++++++++++++++++
 tb/tb_gl_rasterizer_stream.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gl_rasterizer_stream.sv
// Triangle rasteriser: accepts three signed vertices and streams covered pixel coordinates row-major.
// Latency: 3 cycles from triangle transfer to the first fragment; 2 cycles to tri_done for empty or degenerate triangles.
// Backpressure: frag_ready low holds the output register and a one-entry pending stage; traversal stalls on a covered pixel until space frees.
module gl_rasterizer_stream #(
    parameter int COORD_W   = 16,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int CULL_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [COORD_W-1:0] x1,
    input  logic signed [COORD_W-1:0] y1,
    input  logic signed [COORD_W-1:0] x2,
    input  logic signed [COORD_W-1:0] y2,
    input  logic signed [COORD_W-1:0] x3,
    input  logic signed [COORD_W-1:0] y3,
    input  logic                      tri_valid,
    output logic                      tri_ready,
    output logic [COORD_W-1:0]        frag_x,
    output logic [COORD_W-1:0]        frag_y,
    output logic                      frag_valid,
    input  logic                      frag_ready,
    output logic                      tri_done,
    output logic [2*COORD_W-1:0]      frag_count
);

    // Edge accumulators: a product of two (COORD_W+1)-bit differences plus one more bit for the
    // subtraction, with headroom so the incremental walk can never wrap.
    localparam int EW = 2*COORD_W + 4;

    typedef logic signed [COORD_W-1:0] crd_t;
    typedef logic signed [EW-1:0]      acc_t;
    typedef logic [2*COORD_W-1:0]      cnt_t;
    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

    localparam crd_t XMAX    = crd_t'(SCREEN_W - 1);
    localparam crd_t YMAX    = crd_t'(SCREEN_H - 1);
    localparam crd_t ZERO    = '0;
    localparam crd_t CRD_ONE = crd_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);

    function automatic acc_t sx(input crd_t v);
        return {{(EW-COORD_W){v[COORD_W-1]}}, v};
    endfunction

    function automatic crd_t min3(input crd_t a, input crd_t b, input crd_t c);
        crd_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic crd_t max3(input crd_t a, input crd_t b, input crd_t c);
        crd_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // E_ab(px,py) = (xb-xa)*(py-ya) - (yb-ya)*(px-xa), evaluated once per triangle
    function automatic acc_t edge_at(input crd_t xa, input crd_t ya, input crd_t xb,
                                     input crd_t yb, input crd_t px, input crd_t py);
        return (sx(xb) - sx(xa)) * (sx(py) - sx(ya)) - (sx(yb) - sx(ya)) * (sx(px) - sx(xa));
    endfunction

    state_t state_q;

    // Latched vertices, index 0..2 = vertex 1..3
    crd_t vx_q [3];
    crd_t vy_q [3];

    // Traversal state
    crd_t px_q, py_q;
    crd_t minx_q, maxx_q, maxy_q;
    acc_t e_q    [3];   // edge values at (px_q, py_q)
    acc_t erow_q [3];   // edge values at (minx_q, py_q)
    acc_t dx_q   [3];   // xb-xa: added per new row
    acc_t dy_q   [3];   // yb-ya: subtracted per pixel step
    logic scan_end_q;

    // Pending stage between coverage test and the output register
    logic p_vld_q;
    crd_t p_x_q, p_y_q;

    // Output register and counters
    logic frag_valid_q;
    crd_t frag_x_q, frag_y_q;
    logic tri_done_q;
    cnt_t cnt_q;
    cnt_t frag_count_q;

    // Setup-time values derived from the latched vertices
    crd_t bb_minx_d, bb_maxx_d, bb_miny_d, bb_maxy_d;
    logic bb_empty_d;
    acc_t area_d;
    acc_t e0_d [3];
    acc_t dx_d [3];
    acc_t dy_d [3];

    // Bounding box clipped to the screen, and edge values at its top-left corner
    always_comb begin
        bb_minx_d  = min3(vx_q[0], vx_q[1], vx_q[2]);
        bb_maxx_d  = max3(vx_q[0], vx_q[1], vx_q[2]);
        bb_miny_d  = min3(vy_q[0], vy_q[1], vy_q[2]);
        bb_maxy_d  = max3(vy_q[0], vy_q[1], vy_q[2]);
        if (bb_minx_d < ZERO) bb_minx_d = ZERO;
        if (bb_miny_d < ZERO) bb_miny_d = ZERO;
        if (bb_maxx_d > XMAX) bb_maxx_d = XMAX;
        if (bb_maxy_d > YMAX) bb_maxy_d = YMAX;
        bb_empty_d = (bb_minx_d > bb_maxx_d) || (bb_miny_d > bb_maxy_d);

        area_d  = edge_at(vx_q[0], vy_q[0], vx_q[1], vy_q[1], vx_q[2], vy_q[2]);
        e0_d[0] = edge_at(vx_q[0], vy_q[0], vx_q[1], vy_q[1], bb_minx_d, bb_miny_d);
        e0_d[1] = edge_at(vx_q[1], vy_q[1], vx_q[2], vy_q[2], bb_minx_d, bb_miny_d);
        e0_d[2] = edge_at(vx_q[2], vy_q[2], vx_q[0], vy_q[0], bb_minx_d, bb_miny_d);
        dx_d[0] = sx(vx_q[1]) - sx(vx_q[0]);
        dx_d[1] = sx(vx_q[2]) - sx(vx_q[1]);
        dx_d[2] = sx(vx_q[0]) - sx(vx_q[2]);
        dy_d[0] = sx(vy_q[1]) - sx(vy_q[0]);
        dy_d[1] = sx(vy_q[2]) - sx(vy_q[1]);
        dy_d[2] = sx(vy_q[0]) - sx(vy_q[2]);
    end

    logic all_pos, all_neg, covered;
    logic slot_free, p_fire, p_accept, trav_adv;
    logic last_px, last_py;

    // Coverage of the current pixel and the handshake/advance decisions
    always_comb begin
        all_pos = 1'b1;
        all_neg = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (e_q[k][EW-1]) all_pos = 1'b0;
            if (!(e_q[k][EW-1] || (e_q[k] == '0))) all_neg = 1'b0;
        end
        covered   = all_pos || ((CULL_MODE == 0) && all_neg);
        slot_free = !frag_valid_q || frag_ready;
        p_fire    = p_vld_q && slot_free;
        p_accept  = !p_vld_q || p_fire;
        trav_adv  = (state_q == SCAN) && !scan_end_q && (!covered || p_accept);
        last_px   = (px_q == maxx_q);
        last_py   = (py_q == maxy_q);
    end

    // Control FSM, traversal, pending stage and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            frag_valid_q <= 1'b0;
            frag_x_q     <= '0;
            frag_y_q     <= '0;
            tri_done_q   <= 1'b0;
            frag_count_q <= '0;
            cnt_q        <= '0;
            p_vld_q      <= 1'b0;
            p_x_q        <= '0;
            p_y_q        <= '0;
            scan_end_q   <= 1'b0;
        end else begin
            tri_done_q <= 1'b0;

            if (p_fire) begin
                frag_valid_q <= 1'b1;
                frag_x_q     <= p_x_q;
                frag_y_q     <= p_y_q;
                cnt_q        <= cnt_q + CNT_ONE;
            end else if (frag_valid_q && frag_ready) begin
                frag_valid_q <= 1'b0;
            end

            if (trav_adv && covered) begin
                p_vld_q <= 1'b1;
                p_x_q   <= px_q;
                p_y_q   <= py_q;
            end else if (p_fire) begin
                p_vld_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (tri_valid) begin
                        vx_q[0] <= x1;
                        vy_q[0] <= y1;
                        vx_q[1] <= x2;
                        vy_q[1] <= y2;
                        vx_q[2] <= x3;
                        vy_q[2] <= y3;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    minx_q     <= bb_minx_d;
                    maxx_q     <= bb_maxx_d;
                    maxy_q     <= bb_maxy_d;
                    px_q       <= bb_minx_d;
                    py_q       <= bb_miny_d;
                    e_q        <= e0_d;
                    erow_q     <= e0_d;
                    dx_q       <= dx_d;
                    dy_q       <= dy_d;
                    cnt_q      <= '0;
                    scan_end_q <= 1'b0;
                    state_q    <= (bb_empty_d || (area_d == '0)) ? DONE : SCAN;
                end
                SCAN: begin
                    if (scan_end_q && !p_vld_q) begin
                        state_q <= DONE;
                    end else if (trav_adv) begin
                        if (last_px) begin
                            if (last_py) begin
                                scan_end_q <= 1'b1;
                            end else begin
                                px_q <= minx_q;
                                py_q <= py_q + CRD_ONE;
                                for (int k = 0; k < 3; k++) begin
                                    erow_q[k] <= erow_q[k] + dx_q[k];
                                    e_q[k]    <= erow_q[k] + dx_q[k];
                                end
                            end
                        end else begin
                            px_q <= px_q + CRD_ONE;
                            for (int k = 0; k < 3; k++) begin
                                e_q[k] <= e_q[k] - dy_q[k];
                            end
                        end
                    end
                end
                DONE: begin
                    if (!frag_valid_q) begin
                        tri_done_q   <= 1'b1;
                        frag_count_q <= cnt_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tri_ready  = (state_q == IDLE) && !rst;
    assign frag_valid = frag_valid_q;
    assign frag_x     = frag_x_q;
    assign frag_y     = frag_y_q;
    assign tri_done   = tri_done_q;
    assign frag_count = frag_count_q;

endmodule

// File: tb/tb_gl_rasterizer_stream.sv
// Bench for gl_rasterizer_stream: three instances (default, back-face culling, 8x8 screen).
// Expected fragments come from a direct edge-function model and are queued before each triangle.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_gl_rasterizer_stream;

    localparam int CW = 16;

    typedef struct {
        int x;
        int y;
    } pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic signed [CW-1:0] ix1, iy1, ix2, iy2, ix3, iy3;
    logic tv, fr;
    int   sel;

    logic tv_a, tv_c, tv_s;
    logic rdy_a, rdy_c, rdy_s;
    logic [CW-1:0] fx_a, fx_c, fx_s, fy_a, fy_c, fy_s;
    logic fv_a, fv_c, fv_s;
    logic td_a, td_c, td_s;
    logic [2*CW-1:0] fc_a, fc_c, fc_s;

    logic o_rdy, o_fv, o_td;
    logic [CW-1:0] o_fx, o_fy;
    logic [2*CW-1:0] o_fc;

    assign tv_a = tv && (sel == 0);
    assign tv_c = tv && (sel == 1);
    assign tv_s = tv && (sel == 2);

    always_comb begin
        o_rdy = rdy_a; o_fv = fv_a; o_td = td_a; o_fx = fx_a; o_fy = fy_a; o_fc = fc_a;
        if (sel == 1) begin
            o_rdy = rdy_c; o_fv = fv_c; o_td = td_c; o_fx = fx_c; o_fy = fy_c; o_fc = fc_c;
        end else if (sel == 2) begin
            o_rdy = rdy_s; o_fv = fv_s; o_td = td_s; o_fx = fx_s; o_fy = fy_s; o_fc = fc_s;
        end
    end

    gl_rasterizer_stream #(.COORD_W(CW)) u_a (
        .clk(clk), .rst(rst),
        .x1(ix1), .y1(iy1), .x2(ix2), .y2(iy2), .x3(ix3), .y3(iy3),
        .tri_valid(tv_a), .tri_ready(rdy_a),
        .frag_x(fx_a), .frag_y(fy_a), .frag_valid(fv_a), .frag_ready(fr),
        .tri_done(td_a), .frag_count(fc_a)
    );

    gl_rasterizer_stream #(.COORD_W(CW), .CULL_MODE(1)) u_c (
        .clk(clk), .rst(rst),
        .x1(ix1), .y1(iy1), .x2(ix2), .y2(iy2), .x3(ix3), .y3(iy3),
        .tri_valid(tv_c), .tri_ready(rdy_c),
        .frag_x(fx_c), .frag_y(fy_c), .frag_valid(fv_c), .frag_ready(fr),
        .tri_done(td_c), .frag_count(fc_c)
    );

    gl_rasterizer_stream #(.COORD_W(CW), .SCREEN_W(8), .SCREEN_H(8)) u_s (
        .clk(clk), .rst(rst),
        .x1(ix1), .y1(iy1), .x2(ix2), .y2(iy2), .x3(ix3), .y3(iy3),
        .tri_valid(tv_s), .tri_ready(rdy_s),
        .frag_x(fx_s), .frag_y(fy_s), .frag_valid(fv_s), .frag_ready(fr),
        .tri_done(td_s), .frag_count(fc_s)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;
    pix_t exp_q[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference coverage straight from the edge-function definition
    task automatic push_expected(input int ax, input int ay, input int bx, input int by,
                                 input int cx, input int cy, input int sw, input int sh,
                                 input int cull);
        int minx, maxx, miny, maxy;
        longint area, e1, e2, e3;
        pix_t p;
        minx = ax; if (bx < minx) minx = bx; if (cx < minx) minx = cx;
        maxx = ax; if (bx > maxx) maxx = bx; if (cx > maxx) maxx = cx;
        miny = ay; if (by < miny) miny = by; if (cy < miny) miny = cy;
        maxy = ay; if (by > maxy) maxy = by; if (cy > maxy) maxy = cy;
        if (minx < 0) minx = 0;
        if (miny < 0) miny = 0;
        if (maxx > sw - 1) maxx = sw - 1;
        if (maxy > sh - 1) maxy = sh - 1;
        area = longint'(bx - ax) * (cy - ay) - longint'(by - ay) * (cx - ax);
        if (area == 0) return;
        for (int py = miny; py <= maxy; py++) begin
            for (int px = minx; px <= maxx; px++) begin
                e1 = longint'(bx - ax) * (py - ay) - longint'(by - ay) * (px - ax);
                e2 = longint'(cx - bx) * (py - by) - longint'(cy - by) * (px - bx);
                e3 = longint'(ax - cx) * (py - cy) - longint'(ay - cy) * (px - cx);
                if ((e1 >= 0 && e2 >= 0 && e3 >= 0) ||
                    (cull == 0 && e1 <= 0 && e2 <= 0 && e3 <= 0)) begin
                    p.x = px;
                    p.y = py;
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    // Sends one triangle and scoreboards the fragment stream until tri_done (or abort_n accepted).
    // mode 0: frag_ready held high; mode 1: frag_ready cycles 1,0,0,1.
    task automatic run_tri(input int s, input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int sw, input int sh, input int cull,
                           input int mode, input int abort_n, input string tag,
                           output int got, output int lat_first, output int lat_done,
                           output bit saw_vld, output pix_t first_p, output pix_t last_p);
        int  k, pat;
        bit  done, prev_stall;
        logic [CW-1:0] hx, hy;
        pix_t e;
        exp_q.delete();
        push_expected(ax, ay, bx, by, cx, cy, sw, sh, cull);
        got = 0; lat_first = -1; lat_done = -1; saw_vld = 0;
        first_p.x = -1; first_p.y = -1; last_p.x = -1; last_p.y = -1;
        done = 0; prev_stall = 0; hx = '0; hy = '0; pat = 0;
        sel = s;
        @(negedge clk);
        ix1 = CW'(ax); iy1 = CW'(ay); ix2 = CW'(bx); iy2 = CW'(by); ix3 = CW'(cx); iy3 = CW'(cy);
        tv = 1'b1;
        chk({tag, " tri_ready"}, o_rdy, 1);
        @(negedge clk);
        tv = 1'b0;
        // Inputs are ignored once the triangle is taken
        ix1 = 16'sd300; iy1 = -16'sd7; ix2 = 16'sd3; iy2 = 16'sd200; ix3 = -16'sd90; iy3 = 16'sd1;
        k = 0;
        while (!done && k < 2000) begin
            fr = (mode == 0) ? 1'b1 : ((pat % 4) == 0 || (pat % 4) == 3);
            pat++;
            if (prev_stall) begin
                chk({tag, " stall valid"}, o_fv, 1);
                chk({tag, " stall x"}, o_fx, hx);
                chk({tag, " stall y"}, o_fy, hy);
            end
            if (o_fv && !saw_vld) begin
                saw_vld = 1;
                lat_first = k;
            end
            if (o_fv && fr) begin
                got++;
                if (exp_q.size() == 0) begin
                    chk({tag, " unexpected fragment"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, " frag x"}, o_fx, e.x);
                    chk({tag, " frag y"}, o_fy, e.y);
                end
                if (got == 1) begin
                    first_p.x = int'(o_fx); first_p.y = int'(o_fy);
                end
                last_p.x = int'(o_fx); last_p.y = int'(o_fy);
                if (sw == 8) chk({tag, " in screen"}, (o_fx < 8) && (o_fy < 8), 1);
                if (abort_n > 0 && got == abort_n) return;
            end
            prev_stall = o_fv && !fr;
            hx = o_fx;
            hy = o_fy;
            if (o_td) begin
                done = 1;
                lat_done = k;
                chk({tag, " frag_count"}, o_fc, got);
                chk({tag, " leftover expected"}, exp_q.size(), 0);
            end else begin
                @(negedge clk);
                k++;
            end
        end
        if (!done) chk({tag, " tri_done timeout"}, 0, 1);
        fr = 1'b1;
    endtask

    initial begin
        int   got, lf, ld, cnt_bad;
        bit   sv;
        pix_t fp, lp;

        rst = 1'b1; tv = 1'b0; fr = 1'b1; sel = 0;
        ix1 = '0; iy1 = '0; ix2 = '0; iy2 = '0; ix3 = '0; iy3 = '0;
        repeat (3) @(negedge clk);
        chk("reset tri_ready", rdy_a, 0);
        chk("reset frag_valid", fv_a, 0);
        chk("reset tri_done", td_a, 0);
        chk("reset frag_count", fc_a, 0);
        chk("reset frag_x", fx_a, 0);
        chk("reset frag_y", fy_a, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset tri_ready", rdy_a, 1);

        // Right triangle, counter-clockwise, free-flowing output
        run_tri(0, 0, 0, 4, 0, 0, 4, 640, 480, 0, 0, 0, "ccw", got, lf, ld, sv, fp, lp);
        chk("ccw count", got, 15);
        chk("ccw latency", lf, 3);
        chk("ccw first x", fp.x, 0);
        chk("ccw first y", fp.y, 0);
        chk("ccw last x", lp.x, 0);
        chk("ccw last y", lp.y, 4);
        chk("ccw frag_count final", fc_a, 15);

        // Clockwise winding on both culling modes
        run_tri(0, 0, 0, 0, 4, 4, 0, 640, 480, 0, 0, 0, "cw nocull", got, lf, ld, sv, fp, lp);
        chk("cw nocull count", got, 15);
        run_tri(1, 0, 0, 0, 4, 4, 0, 640, 480, 1, 0, 0, "cw cull", got, lf, ld, sv, fp, lp);
        chk("cw cull count", got, 0);
        chk("cw cull frag_valid seen", sv, 0);
        chk("cw cull done seen", ld >= 0, 1);
        run_tri(1, 0, 0, 4, 0, 0, 4, 640, 480, 1, 0, 0, "ccw cull", got, lf, ld, sv, fp, lp);
        chk("ccw cull count", got, 15);

        // Same triangle with a stalling consumer
        run_tri(0, 0, 0, 4, 0, 0, 4, 640, 480, 0, 1, 0, "stall", got, lf, ld, sv, fp, lp);
        chk("stall count", got, 15);
        chk("stall frag_count", fc_a, 15);

        // Large triangle clipped to an 8x8 screen
        run_tri(2, -10, -10, 20, -10, -10, 20, 8, 8, 0, 0, 0, "clip", got, lf, ld, sv, fp, lp);
        chk("clip count", got, 54);
        chk("clip frag_count", fc_s, 54);

        // Degenerate and fully off-screen triangles
        run_tri(0, 0, 0, 2, 2, 4, 4, 640, 480, 0, 0, 0, "degen", got, lf, ld, sv, fp, lp);
        chk("degen count", got, 0);
        chk("degen done latency", ld, 2);
        chk("degen frag_count", fc_a, 0);
        run_tri(0, -10, -10, -5, -10, -10, -5, 640, 480, 0, 0, 0, "offscreen", got, lf, ld, sv, fp, lp);
        chk("offscreen count", got, 0);
        chk("offscreen done latency", ld, 2);

        // Reset after the fifth fragment, then a clean triangle
        run_tri(0, 0, 0, 4, 0, 0, 4, 640, 480, 0, 0, 5, "abort", got, lf, ld, sv, fp, lp);
        chk("abort accepted before reset", got, 5);
        @(negedge clk);
        rst = 1'b1;
        fr  = 1'b0;
        @(negedge clk);
        chk("abort rst frag_valid", fv_a, 0);
        chk("abort rst tri_ready", rdy_a, 0);
        @(negedge clk);
        rst = 1'b0;
        fr  = 1'b1;
        @(negedge clk);
        chk("abort tri_ready after reset", rdy_a, 1);
        cnt_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (fv_a || td_a) cnt_bad++;
            @(negedge clk);
        end
        chk("abort quiet after reset", cnt_bad, 0);
        exp_q.delete();
        run_tri(0, 0, 0, 4, 0, 0, 4, 640, 480, 0, 0, 0, "rerun", got, lf, ld, sv, fp, lp);
        chk("rerun count", got, 15);
        chk("rerun frag_count", fc_a, 15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
